// File: rtl/cache_l2_responder.sv
// L2 responder: direct-mapped write-back L2 serving L1 block reads,
// word write-throughs and block write-backs; evicts/fills over mem req/ack.
// Ports:
//   clk, reset (async, active-high)
//   l1_address, read/write/write_back_to_l2_request, l1_write_data,
//   write_back_data                       : L1 request side
//   l2_ready, read_block_data,
//   write_to_l2_verified,
//   write_back_to_l2_verified             : L1 response side (registered)
//   mem_read_request, mem_write_request,
//   mem_address, mem_write_data           : next-level request (registered)
//   mem_read_data, mem_ack                : next-level completion
module cache_l2_responder #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int BLOCK_WIDTH   = 128,
  parameter int NUM_SETS      = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [ADDRESS_WIDTH-1:0] l1_address,
  input  logic                     read_from_l2_request,
  input  logic                     write_to_l2_request,
  input  logic                     write_back_to_l2_request,
  input  logic [DATA_WIDTH-1:0]    l1_write_data,
  input  logic [BLOCK_WIDTH-1:0]   write_back_data,
  output logic                     l2_ready,
  output logic [BLOCK_WIDTH-1:0]   read_block_data,
  output logic                     write_to_l2_verified,
  output logic                     write_back_to_l2_verified,
  output logic                     mem_read_request,
  output logic                     mem_write_request,
  output logic [ADDRESS_WIDTH-1:0] mem_address,
  output logic [BLOCK_WIDTH-1:0]   mem_write_data,
  input  logic [BLOCK_WIDTH-1:0]   mem_read_data,
  input  logic                     mem_ack
);

  localparam int WORDS  = BLOCK_WIDTH / DATA_WIDTH;
  localparam int OFF_W  = $clog2(BLOCK_WIDTH / 8);
  localparam int BSEL_W = $clog2(DATA_WIDTH / 8);
  localparam int WSEL_W = $clog2(WORDS);
  localparam int IDX_W  = $clog2(NUM_SETS);
  localparam int TAG_W  = ADDRESS_WIDTH - 2 - IDX_W - OFF_W;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    EVICT,
    FILL,
    RESPOND
  } state_t;

  typedef enum logic [1:0] {
    RQ_RD,
    RQ_WR,
    RQ_WB
  } req_t;

  state_t state;
  state_t state_n;

  req_t                   req_q;
  logic [TAG_W-1:0]       tag_q;
  logic [IDX_W-1:0]       idx_q;
  logic [WSEL_W-1:0]      woff_q;
  logic [DATA_WIDTH-1:0]  wdata_q;
  logic [BLOCK_WIDTH-1:0] wblk_q;

  logic [BLOCK_WIDTH-1:0] data_mem [NUM_SETS];
  logic [TAG_W-1:0]       tag_mem  [NUM_SETS];
  logic [NUM_SETS-1:0]    valid;
  logic [NUM_SETS-1:0]    dirty;

  logic                   any_req;
  logic [BLOCK_WIDTH-1:0] line_cur;
  logic [TAG_W-1:0]       vtag;
  logic                   hit;
  logic                   victim_dirty;

  logic                   line_we;
  logic [BLOCK_WIDTH-1:0] line_wd;
  logic                   dirty_we;
  logic                   dirty_wd;
  logic                   rdata_load;
  logic [BLOCK_WIDTH-1:0] rdata_wd;

  // Processor id and byte-in-word bits take no part in lookup.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{l1_address[ADDRESS_WIDTH-1 -: 2],
                              l1_address[BSEL_W-1:0]};

  function automatic logic [BLOCK_WIDTH-1:0] merge_word(
    input logic [BLOCK_WIDTH-1:0] line,
    input logic [DATA_WIDTH-1:0]  w,
    input logic [WSEL_W-1:0]      off
  );
    logic [BLOCK_WIDTH-1:0] r;
    r = line;
    r[int'(off)*DATA_WIDTH +: DATA_WIDTH] = w;
    return r;
  endfunction

  assign any_req = read_from_l2_request
                 | write_to_l2_request
                 | write_back_to_l2_request;

  assign line_cur     = data_mem[idx_q];
  assign vtag         = tag_mem[idx_q];
  assign hit          = valid[idx_q] && (vtag == tag_q);
  assign victim_dirty = valid[idx_q] && dirty[idx_q];

  always_comb begin
    state_n    = state;
    line_we    = 1'b0;
    line_wd    = line_cur;
    dirty_we   = 1'b0;
    dirty_wd   = 1'b0;
    rdata_load = 1'b0;
    rdata_wd   = line_cur;
    case (state)
      IDLE: begin
        if (any_req) state_n = LOOKUP;
      end
      LOOKUP: begin
        if (hit) begin
          state_n = RESPOND;
          case (req_q)
            RQ_WR: begin
              line_we  = 1'b1;
              line_wd  = merge_word(line_cur, wdata_q, woff_q);
              dirty_we = 1'b1;
              dirty_wd = 1'b1;
            end
            RQ_WB: begin
              line_we  = 1'b1;
              line_wd  = wblk_q;
              dirty_we = 1'b1;
              dirty_wd = 1'b1;
            end
            default: rdata_load = 1'b1;
          endcase
        end else if (victim_dirty) begin
          state_n = EVICT;
        end else if (req_q == RQ_WB) begin
          // Full-block write-back needs no fill on a miss.
          state_n  = RESPOND;
          line_we  = 1'b1;
          line_wd  = wblk_q;
          dirty_we = 1'b1;
          dirty_wd = 1'b1;
        end else begin
          state_n = FILL;
        end
      end
      EVICT: begin
        if (mem_ack) begin
          dirty_we = 1'b1;
          dirty_wd = 1'b0;
          if (req_q == RQ_WB) begin
            state_n  = RESPOND;
            line_we  = 1'b1;
            line_wd  = wblk_q;
            dirty_wd = 1'b1;
          end else begin
            state_n = FILL;
          end
        end
      end
      FILL: begin
        if (mem_ack) begin
          state_n  = RESPOND;
          line_we  = 1'b1;
          dirty_we = 1'b1;
          dirty_wd = (req_q == RQ_WR);
          if (req_q == RQ_WR) begin
            line_wd = merge_word(mem_read_data, wdata_q, woff_q);
          end else begin
            line_wd = mem_read_data;
          end
          rdata_load = (req_q == RQ_RD);
          rdata_wd   = mem_read_data;
        end
      end
      RESPOND: begin
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Outputs are registered from the next state so that request lines
  // and response pulses line up exactly with state occupancy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state                     <= IDLE;
      req_q                     <= RQ_RD;
      tag_q                     <= '0;
      idx_q                     <= '0;
      woff_q                    <= '0;
      wdata_q                   <= '0;
      wblk_q                    <= '0;
      valid                     <= '0;
      dirty                     <= '0;
      l2_ready                  <= 1'b0;
      read_block_data           <= '0;
      write_to_l2_verified      <= 1'b0;
      write_back_to_l2_verified <= 1'b0;
      mem_read_request          <= 1'b0;
      mem_write_request         <= 1'b0;
      mem_address               <= '0;
      mem_write_data            <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && any_req) begin
        if (write_back_to_l2_request) begin
          req_q <= RQ_WB;
        end else if (write_to_l2_request) begin
          req_q <= RQ_WR;
        end else begin
          req_q <= RQ_RD;
        end
        tag_q   <= l1_address[OFF_W+IDX_W +: TAG_W];
        idx_q   <= l1_address[OFF_W +: IDX_W];
        woff_q  <= l1_address[BSEL_W +: WSEL_W];
        wdata_q <= l1_write_data;
        wblk_q  <= write_back_data;
      end
      if (line_we)    valid[idx_q] <= 1'b1;
      if (dirty_we)   dirty[idx_q] <= dirty_wd;
      if (rdata_load) read_block_data <= rdata_wd;

      l2_ready <= (state_n == RESPOND) && (req_q == RQ_RD);
      write_to_l2_verified <=
        (state_n == RESPOND) && (req_q == RQ_WR);
      write_back_to_l2_verified <=
        (state_n == RESPOND) && (req_q == RQ_WB);

      mem_write_request <= (state_n == EVICT);
      mem_read_request  <= (state_n == FILL);
      if (state_n == EVICT) begin
        mem_address    <= {2'b00, vtag, idx_q, {OFF_W{1'b0}}};
        mem_write_data <= line_cur;
      end else if (state_n == FILL) begin
        mem_address <= {2'b00, tag_q, idx_q, {OFF_W{1'b0}}};
      end
    end
  end

  // Line storage carries no reset; valid bits gate every use.
  always_ff @(posedge clk) begin
    if (line_we) begin
      data_mem[idx_q] <= line_wd;
      tag_mem[idx_q]  <= tag_q;
    end
  end

endmodule

// File: tb/tb_cache_l2_responder.sv
// Scoreboard bench for cache_l2_responder: directed L1 requests,
// a next-level memory model, and a monitor checking every output event.
module tb_cache_l2_responder;

  localparam int K_RDY = 0;
  localparam int K_WV  = 1;
  localparam int K_WBV = 2;
  localparam int K_MRD = 3;
  localparam int K_MWR = 4;

  localparam logic [127:0] F100 =
    128'h44444444_33333333_22222222_11111111;
  localparam logic [127:0] M100 =
    128'h44444444_33333333_12345678_11111111;
  localparam logic [127:0] BLK_B =
    128'hBBBB0003_BBBB0002_BBBB0001_BBBB0000;
  localparam logic [127:0] BLK_C =
    128'hCCCC0003_CCCC0002_CCCC0001_CCCC0000;

  logic         clk = 1'b0;
  logic         reset;
  logic [31:0]  l1_address;
  logic         read_from_l2_request;
  logic         write_to_l2_request;
  logic         write_back_to_l2_request;
  logic [31:0]  l1_write_data;
  logic [127:0] write_back_data;
  logic         l2_ready;
  logic [127:0] read_block_data;
  logic         write_to_l2_verified;
  logic         write_back_to_l2_verified;
  logic         mem_read_request;
  logic         mem_write_request;
  logic [31:0]  mem_address;
  logic [127:0] mem_write_data;
  logic [127:0] mem_read_data;
  logic         mem_ack;

  always #5 clk = ~clk;

  cache_l2_responder dut (
    .clk                       (clk),
    .reset                     (reset),
    .l1_address                (l1_address),
    .read_from_l2_request      (read_from_l2_request),
    .write_to_l2_request       (write_to_l2_request),
    .write_back_to_l2_request  (write_back_to_l2_request),
    .l1_write_data             (l1_write_data),
    .write_back_data           (write_back_data),
    .l2_ready                  (l2_ready),
    .read_block_data           (read_block_data),
    .write_to_l2_verified      (write_to_l2_verified),
    .write_back_to_l2_verified (write_back_to_l2_verified),
    .mem_read_request          (mem_read_request),
    .mem_write_request         (mem_write_request),
    .mem_address               (mem_address),
    .mem_write_data            (mem_write_data),
    .mem_read_data             (mem_read_data),
    .mem_ack                   (mem_ack)
  );

  typedef struct {
    int           kind;
    logic [31:0]  addr;
    logic [127:0] data;
  } exp_t;

  exp_t sbq[$];
  int   tests = 0;
  int   fails = 0;

  logic [127:0] bmem [logic [31:0]];

  function automatic logic [127:0] fill_pat(input logic [31:0] a);
    if (a == 32'h100) return F100;
    return {a ^ 32'hA5A5_0000, a ^ 32'h5A5A_0000, ~a, a + 32'd1};
  endfunction

  task automatic push(input int k, input logic [31:0] a,
                      input logic [127:0] d);
    exp_t e;
    e.kind = k;
    e.addr = a;
    e.data = d;
    sbq.push_back(e);
  endtask

  task automatic check_ev(input int k, input logic [31:0] a,
                          input logic [127:0] d);
    exp_t e;
    tests++;
    if (sbq.size() == 0) begin
      fails++;
      $display("FAIL sb_unexpected: got kind %0d addr %h data %h",
               k, a, d);
    end else begin
      e = sbq.pop_front();
      if (e.kind != k || e.addr != a || e.data != d) begin
        fails++;
        $display("FAIL sb_event: got kind %0d addr %h data %h, want kind %0d addr %h data %h",
                 k, a, d, e.kind, e.addr, e.data);
      end
    end
  endtask

  task automatic chk(input string name, input logic [127:0] got,
                     input logic [127:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  // Monitor: one event per rising mem request or response pulse.
  logic pr = 1'b0;
  logic pw = 1'b0;
  always @(negedge clk) begin
    if (!reset) begin
      if (mem_write_request && !pw)
        check_ev(K_MWR, mem_address, mem_write_data);
      if (mem_read_request && !pr)
        check_ev(K_MRD, mem_address, 128'd0);
      if (l2_ready)
        check_ev(K_RDY, 32'd0, read_block_data);
      if (write_to_l2_verified)
        check_ev(K_WV, 32'd0, 128'd0);
      if (write_back_to_l2_verified)
        check_ev(K_WBV, 32'd0, 128'd0);
    end
    pw = mem_write_request;
    pr = mem_read_request;
  end

  // Next-level memory: acks a few cycles after it sees a request.
  initial begin
    mem_ack       = 1'b0;
    mem_read_data = '0;
    forever begin
      @(posedge clk);
      if (!reset && (mem_read_request || mem_write_request)) begin
        repeat (2) @(posedge clk);
        #1;
        if (mem_write_request) begin
          bmem[mem_address] = mem_write_data;
        end else begin
          mem_read_data = bmem.exists(mem_address) ?
                          bmem[mem_address] : fill_pat(mem_address);
        end
        mem_ack = 1'b1;
        @(posedge clk);
        #1;
        mem_ack = 1'b0;
      end
    end
  end

  function automatic logic pulse_of(input int k);
    case (k)
      K_WV:    return write_to_l2_verified;
      K_WBV:   return write_back_to_l2_verified;
      default: return l2_ready;
    endcase
  endfunction

  // Issue one L1 request, wait for its pulse, optionally check latency.
  task automatic run_req(input int k, input logic [31:0] a,
                         input logic [31:0] w, input logic [127:0] b,
                         input int exp_lat, input string name);
    int  lat;
    logic got;
    @(posedge clk);
    #1;
    l1_address      = a;
    l1_write_data   = w;
    write_back_data = b;
    read_from_l2_request     = (k == K_RDY);
    write_to_l2_request      = (k == K_WV);
    write_back_to_l2_request = (k == K_WBV);
    lat = 0;
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(posedge clk);
      #1;
      lat++;
      if (pulse_of(k)) got = 1'b1;
    end
    read_from_l2_request     = 1'b0;
    write_to_l2_request      = 1'b0;
    write_back_to_l2_request = 1'b0;
    tests++;
    if (!got) begin
      fails++;
      $display("FAIL %s_timeout: got no pulse want pulse", name);
    end else if (exp_lat > 0) begin
      tests++;
      if (lat != exp_lat) begin
        fails++;
        $display("FAIL %s_latency: got %0d want %0d",
                 name, lat, exp_lat);
      end
    end
  endtask

  initial begin
    logic seen;
    reset                    = 1'b1;
    l1_address               = '0;
    read_from_l2_request     = 1'b0;
    write_to_l2_request      = 1'b0;
    write_back_to_l2_request = 1'b0;
    l1_write_data            = '0;
    write_back_data          = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_l2_ready", {127'd0, l2_ready}, 128'd0);
    chk("rst_wv", {127'd0, write_to_l2_verified}, 128'd0);
    chk("rst_wbv", {127'd0, write_back_to_l2_verified}, 128'd0);
    chk("rst_mem_req", {126'd0, mem_read_request, mem_write_request},
        128'd0);
    chk("rst_mem_addr", {96'd0, mem_address}, 128'd0);
    chk("rst_rdata", read_block_data, 128'd0);
    reset = 1'b0;

    push(K_MRD, 32'h100, 128'd0);
    push(K_RDY, 32'd0, F100);
    run_req(K_RDY, 32'h100, 0, 0, 0, "rd_miss_100");

    push(K_RDY, 32'd0, F100);
    run_req(K_RDY, 32'h100, 0, 0, 2, "rd_hit_100");

    push(K_WV, 32'd0, 128'd0);
    run_req(K_WV, 32'h104, 32'h1234_5678, 0, 2, "wr_hit_104");

    push(K_RDY, 32'd0, M100);
    run_req(K_RDY, 32'h100, 0, 0, 2, "rd_merged_100");

    push(K_MWR, 32'h100, M100);
    push(K_MRD, 32'h500, 128'd0);
    push(K_RDY, 32'd0, fill_pat(32'h500));
    run_req(K_RDY, 32'h500, 0, 0, 0, "rd_conflict_500");

    // Write-back and read raised together.
    push(K_WBV, 32'd0, 128'd0);
    push(K_MRD, 32'h300, 128'd0);
    push(K_RDY, 32'd0, fill_pat(32'h300));
    @(posedge clk);
    #1;
    l1_address               = 32'h200;
    write_back_data          = BLK_B;
    write_back_to_l2_request = 1'b1;
    read_from_l2_request     = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(posedge clk);
      #1;
      if (write_back_to_l2_verified) seen = 1'b1;
    end
    chk("simul_wb_pulse", {127'd0, seen}, 128'd1);
    write_back_to_l2_request = 1'b0;
    l1_address               = 32'h300;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(posedge clk);
      #1;
      if (l2_ready) seen = 1'b1;
    end
    chk("simul_rd_pulse", {127'd0, seen}, 128'd1);
    read_from_l2_request = 1'b0;

    push(K_RDY, 32'd0, BLK_B);
    run_req(K_RDY, 32'h200, 0, 0, 2, "rd_hit_200");

    push(K_WBV, 32'd0, 128'd0);
    run_req(K_WBV, 32'h700, 0, BLK_C, 0, "wb_miss_700");

    push(K_RDY, 32'd0, BLK_C);
    run_req(K_RDY, 32'h700, 0, 0, 2, "rd_hit_700");

    // Reset while FILL is waiting for the next level.
    push(K_MRD, 32'hB40, 128'd0);
    @(posedge clk);
    #1;
    l1_address           = 32'hB40;
    read_from_l2_request = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(posedge clk);
      #1;
      if (mem_read_request) seen = 1'b1;
    end
    chk("fill_req_seen", {127'd0, seen}, 128'd1);
    @(negedge clk);
    #1;
    reset                = 1'b1;
    read_from_l2_request = 1'b0;
    #1;
    chk("rst_fill_mem_rd", {127'd0, mem_read_request}, 128'd0);
    chk("rst_fill_outs",
        {123'd0, l2_ready, write_to_l2_verified,
         write_back_to_l2_verified, mem_read_request,
         mem_write_request}, 128'd0);
    chk("rst_fill_addr", {96'd0, mem_address}, 128'd0);
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b0;

    push(K_MRD, 32'hB40, 128'd0);
    push(K_RDY, 32'd0, fill_pat(32'hB40));
    run_req(K_RDY, 32'hB40, 0, 0, 0, "rd_after_rst_b40");

    push(K_MRD, 32'h700, 128'd0);
    push(K_RDY, 32'd0, fill_pat(32'h700));
    run_req(K_RDY, 32'h700, 0, 0, 0, "rd_after_rst_700");

    repeat (5) @(posedge clk);
    #1;
    chk("sb_drained", 128'(sbq.size()), 128'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
